// File: rtl/cpu_mem_sequencer.sv
// CPU memory-cycle sequencer onto the shared SDRAM CPU port.
// One-line 8-byte write-through read cache, ROM write drop, SDRAM timeout.
module cpu_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_dout,
  input  logic        ram_rom_memrq,
  input  logic        writable,
  input  logic [24:0] sdr_addr_in,
  input  logic        flush,
  output logic        cpu_ready,
  output logic [15:0] cpu_din,
  output logic        sdr_req,
  output logic        sdr_we,
  output logic [1:0]  sdr_be,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_wdata,
  input  logic        sdr_ack,
  input  logic [63:0] sdr_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_n, we_n, ready_n, terr_n;
  logic [1:0]    be_n;
  logic [24:0]   addr_n;
  logic [15:0]   wdata_n, din_n;
  logic [15:0]   res, res_n;
  logic [1:0]    word, word_n;
  logic [63:0]   line, line_n;
  logic [21:0]   tag, tag_n;
  logic          valid, valid_n;
  logic          hit;
  logic [15:0]   hit_word;

  assign hit = CACHE_EN && valid &&
               (tag == sdr_addr_in[24:3]);
  assign hit_word = line[{sdr_addr_in[2:1], 4'b0000} +: 16];

  // State, registered outputs and cache line
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sdr_req     <= 1'b0;
      sdr_we      <= 1'b0;
      sdr_be      <= 2'b00;
      sdr_addr    <= '0;
      sdr_wdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_din     <= '0;
      timeout_err <= 1'b0;
      res         <= '0;
      word        <= '0;
      line        <= '0;
      tag         <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sdr_req     <= req_n;
      sdr_we      <= we_n;
      sdr_be      <= be_n;
      sdr_addr    <= addr_n;
      sdr_wdata   <= wdata_n;
      cpu_ready   <= ready_n;
      cpu_din     <= din_n;
      timeout_err <= terr_n;
      res         <= res_n;
      word        <= word_n;
      line        <= line_n;
      tag         <= tag_n;
      valid       <= valid_n;
    end
  end

  // Next-state, next outputs and cache updates
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = sdr_req;
    we_n    = sdr_we;
    be_n    = sdr_be;
    addr_n  = sdr_addr;
    wdata_n = sdr_wdata;
    ready_n = 1'b0;
    din_n   = '0;
    terr_n  = timeout_err;
    res_n   = res;
    word_n  = word;
    line_n  = line;
    tag_n   = tag;
    valid_n = valid;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          res_n  = '0;
          word_n = sdr_addr_in[2:1];
          if (!ram_rom_memrq) begin
            state_n = DONE;
          end else if (cpu_we && !writable) begin
            state_n = DONE;
          end else if (!cpu_we && hit) begin
            res_n   = hit_word;
            state_n = DONE;
          end else if (!cpu_we) begin
            state_n = RD_WAIT;
            cnt_n   = '0;
            req_n   = 1'b1;
            we_n    = 1'b0;
            be_n    = 2'b11;
            addr_n  = {sdr_addr_in[24:3], 3'b000};
          end else begin
            state_n = WR_WAIT;
            cnt_n   = '0;
            req_n   = 1'b1;
            we_n    = 1'b1;
            be_n    = cpu_be;
            addr_n  = sdr_addr_in;
            wdata_n = cpu_dout;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (sdr_ack) begin
          req_n   = 1'b0;
          state_n = DONE;
          if (state == RD_WAIT) begin
            line_n  = sdr_rdata;
            tag_n   = sdr_addr[24:3];
            valid_n = CACHE_EN;
            res_n   = sdr_rdata[{word, 4'b0000} +: 16];
          end else if (valid &&
                       tag == sdr_addr[24:3]) begin
            if (sdr_be[0])
              line_n[{word, 4'b0000} +: 8] = sdr_wdata[7:0];
            if (sdr_be[1])
              line_n[{word, 4'b1000} +: 8] = sdr_wdata[15:8];
          end
        end else if (cnt == CNT_LAST) begin
          req_n   = 1'b0;
          state_n = DONE;
          res_n   = 16'hFFFF;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        ready_n = 1'b1;
        din_n   = res;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush)
      valid_n = 1'b0;
  end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed scoreboard bench for cpu_mem_sequencer.
// Uses a short SDRAM timeout to exercise the abort path.
module tb_cpu_mem_sequencer;

  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [15:0] cpu_dout = '0;
  logic        ram_rom_memrq = 1'b0;
  logic        writable = 1'b0;
  logic [24:0] sdr_addr_in = '0;
  logic        flush = 1'b0;
  logic        cpu_ready;
  logic [15:0] cpu_din;
  logic        sdr_req;
  logic        sdr_we;
  logic [1:0]  sdr_be;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_wdata;
  logic        sdr_ack = 1'b0;
  logic [63:0] sdr_rdata = '0;
  logic        timeout_err;

  int nchecks = 0;
  int nerrors = 0;
  logic [15:0] sb[$];

  cpu_mem_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CACHE_EN(1'b1)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_be(cpu_be),
    .cpu_dout(cpu_dout),
    .ram_rom_memrq(ram_rom_memrq),
    .writable(writable),
    .sdr_addr_in(sdr_addr_in),
    .flush(flush),
    .cpu_ready(cpu_ready),
    .cpu_din(cpu_din),
    .sdr_req(sdr_req),
    .sdr_we(sdr_we),
    .sdr_be(sdr_be),
    .sdr_addr(sdr_addr),
    .sdr_wdata(sdr_wdata),
    .sdr_ack(sdr_ack),
    .sdr_rdata(sdr_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One CPU cycle: ack_n = cycles of sdr_req before ack
  // (0 = never ack), lat = cpu_req to cpu_ready cycles.
  task automatic access(
    input string       tag,
    input logic        we,
    input logic [1:0]  be,
    input logic [15:0] dout,
    input logic        memrq,
    input logic        wr_ok,
    input logic [24:0] addr,
    input logic [15:0] exp_din,
    input int          exp_req,
    input logic        exp_we,
    input logic [1:0]  exp_be,
    input logic [24:0] exp_addr,
    input int          ack_n,
    input logic [63:0] rdata,
    input logic        fl,
    input int          lat
  );
    int  cycles;
    int  req_cycles;
    bit  done;
    logic [15:0] e;
    cpu_req       = 1'b1;
    cpu_we        = we;
    cpu_be        = be;
    cpu_dout      = dout;
    ram_rom_memrq = memrq;
    writable      = wr_ok;
    sdr_addr_in   = addr;
    sb.push_back(exp_din);
    step();
    cpu_req    = 1'b0;
    cycles     = 1;
    req_cycles = 0;
    done       = 0;
    while (!done && cycles < 64) begin
      if (cpu_ready) begin
        done = 1;
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check({tag, "_din"}, cpu_din, e);
        end
        check({tag, "_lat"}, cycles, lat);
        check({tag, "_reqcyc"}, req_cycles, exp_req);
        check({tag, "_req_low"}, sdr_req, 0);
      end else begin
        if (sdr_req) begin
          req_cycles++;
          if (req_cycles == 1) begin
            check({tag, "_addr"}, sdr_addr, exp_addr);
            check({tag, "_we"}, sdr_we, exp_we);
            check({tag, "_be"}, sdr_be, exp_be);
            if (exp_we)
              check({tag, "_wdata"}, sdr_wdata, dout);
          end
          if (ack_n != 0 && req_cycles == ack_n) begin
            sdr_ack   = 1'b1;
            sdr_rdata = rdata;
            flush     = fl;
          end
        end
        step();
        sdr_ack = 1'b0;
        flush   = 1'b0;
        cycles++;
      end
    end
    check({tag, "_ready_seen"}, done, 1);
    step();
    check({tag, "_ready_pulse"}, cpu_ready, 0);
    check({tag, "_din_zero"}, cpu_din, 0);
  endtask

  initial begin
    bit ready_seen;
    repeat (3) step();
    check("rst_ready", cpu_ready, 0);
    check("rst_din", cpu_din, 0);
    check("rst_req", sdr_req, 0);
    check("rst_we", sdr_we, 0);
    check("rst_be", sdr_be, 0);
    check("rst_addr", sdr_addr, 0);
    check("rst_wdata", sdr_wdata, 0);
    check("rst_terr", timeout_err, 0);
    reset = 1'b0;
    step();

    access("t1_miss", 0, 2'b11, 16'h0, 1, 1,
           25'h0100012, 16'h2222, 5, 0, 2'b11,
           25'h0100010, 5,
           64'h4444_3333_2222_1111, 0, 7);
    access("t2_hit", 0, 2'b11, 16'h0, 1, 1,
           25'h0100016, 16'h4444, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);
    access("t3_wr", 1, 2'b01, 16'hABCD, 1, 1,
           25'h0100016, 16'h0000, 3, 1, 2'b01,
           25'h0100016, 3, 64'h0, 0, 5);
    access("t3_rdhit", 0, 2'b11, 16'h0, 1, 1,
           25'h0100016, 16'h44CD, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);
    access("t3_w0", 0, 2'b11, 16'h0, 1, 1,
           25'h0100010, 16'h1111, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);
    access("t4_romwr", 1, 2'b11, 16'h5A5A, 1, 0,
           25'h0100014, 16'h0000, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);
    access("t4_nomem", 0, 2'b11, 16'h0, 0, 1,
           25'h0100012, 16'h0000, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);
    access("t4_keep", 0, 2'b11, 16'h0, 1, 1,
           25'h0100014, 16'h3333, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);

    check("t5_terr_pre", timeout_err, 0);
    access("t5_to", 0, 2'b11, 16'h0, 1, 1,
           25'h0200006, 16'hFFFF, TO, 0, 2'b11,
           25'h0200000, 0, 64'h0, 0, TO + 2);
    check("t5_terr", timeout_err, 1);
    sdr_ack   = 1'b1;
    sdr_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    sdr_ack = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready || sdr_req) ready_seen = 1;
      step();
    end
    check("t5_late_ack", ready_seen, 0);
    check("t5_terr_sticky", timeout_err, 1);
    access("t5_cache", 0, 2'b11, 16'h0, 1, 1,
           25'h0100016, 16'h44CD, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);

    access("t6_fill_fl", 0, 2'b11, 16'h0, 1, 1,
           25'h0300008, 16'h5555, 2, 0, 2'b11,
           25'h0300008, 2,
           64'h8888_7777_6666_5555, 1, 4);
    access("t6_remiss", 0, 2'b11, 16'h0, 1, 1,
           25'h030000C, 16'h7777, 1, 0, 2'b11,
           25'h0300008, 1,
           64'h8888_7777_6666_5555, 0, 3);
    access("t6_hit", 0, 2'b11, 16'h0, 1, 1,
           25'h030000A, 16'h6666, 0, 0, 2'b11,
           25'h0, 0, 64'h0, 0, 2);

    cpu_req       = 1'b1;
    cpu_we        = 1'b0;
    ram_rom_memrq = 1'b1;
    sdr_addr_in   = 25'h0400002;
    step();
    cpu_req = 1'b0;
    step();
    check("t7_req_up", sdr_req, 1);
    reset = 1'b1;
    step();
    check("t7_req_drop", sdr_req, 0);
    check("t7_terr_clr", timeout_err, 0);
    reset     = 1'b0;
    sdr_ack   = 1'b1;
    sdr_rdata = 64'h1234_1234_1234_1234;
    step();
    sdr_ack = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ready) ready_seen = 1;
      step();
    end
    check("t7_no_ready", ready_seen, 0);
    access("t7_cold", 0, 2'b11, 16'h0, 1, 1,
           25'h030000A, 16'hBBBB, 2, 0, 2'b11,
           25'h0300008, 2,
           64'hDDDD_CCCC_BBBB_AAAA, 0, 4);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
